// File: rtl/mult_pkg.sv
// Shared types and helpers for the slice-by-slice sequential multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  // Width of a slice index: $clog2(n), with a floor of one bit so a
  // single-slice operand still gets a legal index vector.
  function automatic int slice_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_pair_sel.sv
// Combinational pair selector: finds the next (i,j) slice pair, in row-major
// order (i outer, j inner), whose A and B slices are both non-zero.
// With first=1 the search starts at (0,0) inclusive; otherwise it starts
// strictly after (cur_i,cur_j).
module mult_pair_sel #(
  parameter int NA = 2,
  parameter int NB = 2,
  parameter int IW = 1,
  parameter int JW = 1
) (
  input  logic [NA-1:0] za,
  input  logic [NB-1:0] zb,
  input  logic [IW-1:0] cur_i,
  input  logic [JW-1:0] cur_j,
  input  logic          first,
  output logic [IW-1:0] nxt_i,
  output logic [JW-1:0] nxt_j,
  output logic          found
);

  // Lowest linear index that is a valid pair and lies past the current one.
  always_comb begin
    int cur_lin;
    // NOTE: every output gets a default before the search loop; without it
    // the "not found" path would leave nxt_i/nxt_j unassigned and infer latches.
    found   = 1'b0;
    nxt_i   = '0;
    nxt_j   = '0;
    cur_lin = int'(cur_i) * NB + int'(cur_j);
    for (int k = 0; k < NA * NB; k++) begin
      if (!found && !za[k / NB] && !zb[k % NB] && (first || (k > cur_lin))) begin
        found = 1'b1;
        nxt_i = IW'(k / NB);
        nxt_j = JW'(k % NB);
      end
    end
  end

endmodule

// File: rtl/mult_nxm_seq_fast.sv
// Parametrised unsigned sequential multiplier. Operands are split into
// SLICE-bit words; one SLICE x SLICE partial product per cycle is shifted
// into place and accumulated into the product register.
// Build option: define MULT_SKIP_ZERO_EN to skip every slice pair in which
// either slice is zero (variable latency K+1). Without it all NA*NB pairs
// are processed (fixed latency NA*NB+1); the product is the same.
module mult_nxm_seq_fast
  import mult_pkg::*;
#(
  parameter int A_WIDTH = 32,
  parameter int B_WIDTH = 32,
  parameter int SLICE   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [A_WIDTH-1:0]         a,
  input  logic [B_WIDTH-1:0]         b,
  output logic                       busy,
  output logic                       done,
  output logic [A_WIDTH+B_WIDTH-1:0] product
);

  localparam int NA = A_WIDTH / SLICE;
  localparam int NB = B_WIDTH / SLICE;
  localparam int IW = slice_idx_w(NA);
  localparam int JW = slice_idx_w(NB);
  localparam int PW = A_WIDTH + B_WIDTH;

  mult_state_t          state_q, state_d;
  logic [A_WIDTH-1:0]   a_q, a_d;
  logic [B_WIDTH-1:0]   b_q, b_d;
  logic [IW-1:0]        pi_q, pi_d;
  logic [JW-1:0]        pj_q, pj_d;
  logic [PW-1:0]        product_q, product_d;

  logic [NA-1:0]        za_cur;
  logic [NB-1:0]        zb_cur;
  logic                 sel_first;
  logic [IW-1:0]        sel_i;
  logic [JW-1:0]        sel_j;
  logic                 sel_found;

  logic [SLICE-1:0]     a_slice;
  logic [SLICE-1:0]     b_slice;
  logic [2*SLICE-1:0]   pp;
  logic [PW-1:0]        pp_shifted;

`ifdef MULT_SKIP_ZERO_EN
  logic [NA-1:0] za_in, za_q, za_d;
  logic [NB-1:0] zb_in, zb_q, zb_d;

  // Zero masks of the incoming operands, one bit per slice.
  always_comb begin
    za_in = '0;
    zb_in = '0;
    for (int i = 0; i < NA; i++) za_in[i] = (a[i*SLICE +: SLICE] == '0);
    for (int j = 0; j < NB; j++) zb_in[j] = (b[j*SLICE +: SLICE] == '0);
  end

  // Masks are latched on acceptance; the first search uses the live masks.
  always_comb begin
    za_d = za_q;
    zb_d = zb_q;
    if (state_q == IDLE && start) begin
      za_d = za_in;
      zb_d = zb_in;
    end
    za_cur = (state_q == IDLE) ? za_in : za_q;
    zb_cur = (state_q == IDLE) ? zb_in : zb_q;
  end

  // Mask registers for the operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      za_q <= '0;
      zb_q <= '0;
    end else begin
      za_q <= za_d;
      zb_q <= zb_d;
    end
  end
`else
  // Every pair is valid: no masks are built.
  assign za_cur = '0;
  assign zb_cur = '0;
`endif

  assign sel_first = (state_q == IDLE);

  mult_pair_sel #(
    .NA (NA),
    .NB (NB),
    .IW (IW),
    .JW (JW)
  ) u_pair_sel (
    .za    (za_cur),
    .zb    (zb_cur),
    .cur_i (pi_q),
    .cur_j (pj_q),
    .first (sel_first),
    .nxt_i (sel_i),
    .nxt_j (sel_j),
    .found (sel_found)
  );

  // Slice muxes and the shifted partial product for the current pair.
  always_comb begin
    a_slice    = a_q[pi_q*SLICE +: SLICE];
    b_slice    = b_q[pj_q*SLICE +: SLICE];
    pp         = (2*SLICE)'(a_slice) * (2*SLICE)'(b_slice);
    pp_shifted = PW'(pp) << (SLICE * (int'(pi_q) + int'(pj_q)));
  end

  // Next-state, operand capture, pointer advance and accumulation.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    pi_d      = pi_q;
    pj_d      = pj_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d       = a;
          b_d       = b;
          product_d = '0;
          pi_d      = sel_i;
          pj_d      = sel_j;
          state_d   = sel_found ? MULT : DONE;
        end
      end
      MULT: begin
        product_d = product_q + pp_shifted;
        if (sel_found) begin
          pi_d = sel_i;
          pj_d = sel_j;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      pi_q      <= '0;
      pj_q      <= '0;
      product_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, regardless of statement order.
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      pi_q      <= pi_d;
      pj_q      <= pj_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == MULT);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_mult_nxm_seq_fast.sv
// Self-checking bench for mult_nxm_seq_fast. Honors MULT_SKIP_ZERO_EN the
// same way the design does, so expected latency follows the build.
module tb_mult_nxm_seq_fast;

  localparam int AW = 32;
  localparam int BW = 32;
  localparam int SL = 16;
  localparam int NA = AW / SL;
  localparam int NB = BW / SL;
  localparam int PW = AW + BW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] a;
  logic [BW-1:0] b;
  logic          busy;
  logic          done;
  logic [PW-1:0] product;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  mult_nxm_seq_fast #(
    .A_WIDTH (AW),
    .B_WIDTH (BW),
    .SLICE   (SL)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Number of partial products the design should spend cycles on.
  function automatic int count_pairs(input logic [AW-1:0] av, input logic [BW-1:0] bv);
`ifdef MULT_SKIP_ZERO_EN
    int n = 0;
    for (int i = 0; i < NA; i++)
      for (int j = 0; j < NB; j++)
        if (((av >> (i * SL)) % (1 << SL)) != 0 && ((bv >> (j * SL)) % (1 << SL)) != 0) n++;
    return n;
`else
    return NA * NB;
`endif
  endfunction

  // One operation from acceptance edge through the first IDLE cycle after DONE.
  // Expects to be called while the DUT is in IDLE, away from the clock edge.
  task automatic run_op(input logic [AW-1:0] av, input logic [BW-1:0] bv,
                        input bit hold, input bit churn);
    int k;
    logic [PW-1:0] exp;
    k   = count_pairs(av, bv);
    exp = PW'(av) * PW'(bv);
    start = 1'b1;
    a = av;
    b = bv;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    for (int c = 1; c <= k + 1; c++) begin
      if (churn) begin
        a = $urandom;
        b = $urandom;
      end
      check($sformatf("busy a=%h b=%h c%0d", av, bv, c), PW'(busy), PW'(c <= k));
      check($sformatf("done a=%h b=%h c%0d", av, bv, c), PW'(done), PW'(c == k + 1));
      if (c == k + 1) check($sformatf("product a=%h b=%h", av, bv), product, exp);
      @(posedge clk); #1;
    end
    check($sformatf("idle busy a=%h b=%h", av, bv), PW'(busy), '0);
    check($sformatf("idle done a=%h b=%h", av, bv), PW'(done), '0);
    check($sformatf("held product a=%h b=%h", av, bv), product, exp);
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [BW-1:0] rb;
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", PW'(busy), '0);
    check("reset done", PW'(done), '0);
    check("reset product", product, '0);
    reset = 1'b0;

    // Directed cases.
    run_op(32'h0000_1234, 32'h0000_5678, 1'b0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(32'h0000_0000, 32'h1234_5678, 1'b0, 1'b0);
    run_op(32'h0001_0000, 32'h0000_0003, 1'b0, 1'b0);

    // Reset in cycle 2 of a long operation: aborts with no done.
    start = 1'b1;
    a = 32'hFFFF_FFFF;
    b = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort busy", PW'(busy), '0);
    check("abort done", PW'(done), '0);
    check("abort product", product, '0);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      check($sformatf("post-abort done c%0d", c), PW'(done), '0);
      @(posedge clk); #1;
    end
    run_op(32'd3, 32'd5, 1'b0, 1'b0);

    // Start held high with operands churning while busy; back-to-back accept.
    run_op(32'h0000_1234, 32'h0000_5678, 1'b1, 1'b1);
    run_op(32'hDEAD_0000, 32'h0000_BEEF, 1'b1, 1'b1);
    start = 1'b0;
    @(posedge clk); #1;

    // Randomized operands with randomly zeroed slices.
    for (int n = 0; n < 24; n++) begin
      ra = $urandom;
      rb = $urandom;
      for (int s = 0; s < NA; s++)
        if ($urandom_range(0, 2) == 0) ra = ra & ~(AW'((1 << SL) - 1) << (s * SL));
      for (int s = 0; s < NB; s++)
        if ($urandom_range(0, 2) == 0) rb = rb & ~(BW'((1 << SL) - 1) << (s * SL));
      run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    start = 1'b0;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
